// File: rtl/pool_reduce.sv
// rtl/pool_reduce.sv - pooling-window reducer: max, plus average when POOL_AVG_EN is defined
// Emits one result per window with a sequential row-major write-back address.
module pool_reduce #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 12,
   parameter int ACC_EXTRA   = 10,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   EN,
   input  logic                   START,
   input  logic                   MODE,
   input  logic [SHIFT_WIDTH-1:0] AVG_SHIFT,
   input  logic                   DIN_VALID,
   input  logic [DATA_WIDTH-1:0]  DIN,
   input  logic                   DIN_PACK,
   input  logic                   DIN_LAST,
   output logic                   DOUT_VALID,
   output logic [DATA_WIDTH-1:0]  DOUT,
   output logic [ADDR_WIDTH-1:0]  DOUT_ADDR,
   output logic                   DOUT_LAST,
   output logic                   BUSY,
   output logic                   ERR
);

`ifdef POOL_AVG_EN
   localparam int ACC_W = DATA_WIDTH + ACC_EXTRA;
`else
   // Guard bits only matter when summing; max fits in the sample width.
   localparam int ACC_W = DATA_WIDTH + (ACC_EXTRA * 0);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] acc, acc_nxt;
   logic                    first, first_nxt;
   logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
   logic                    valid_nxt, last_nxt, err_nxt;
   logic [DATA_WIDTH-1:0]   dout_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;

   logic signed [ACC_W-1:0] din_ext, v_max, v;
   logic [DATA_WIDTH-1:0]   result;

   assign din_ext = ACC_W'(signed'(DIN));
   assign v_max   = (acc > din_ext) ? acc : din_ext;

`ifdef POOL_AVG_EN
   logic                        mode_r;
   logic [SHIFT_WIDTH-1:0]      shift_r;
   logic signed [ACC_W-1:0]     v_sum, shifted;
   logic [ACC_W-DATA_WIDTH:0]   upper;

   assign v_sum   = acc + din_ext;
   assign v       = first ? din_ext : (mode_r ? v_sum : v_max);
   assign shifted = v >>> shift_r;
   // Result fits when every bit above the output sign bit matches it.
   assign upper   = shifted[ACC_W-1:DATA_WIDTH-1];

   always_comb begin
      if (!mode_r)
         result = v[DATA_WIDTH-1:0];
      else if ((&upper) || !(|upper))
         result = shifted[DATA_WIDTH-1:0];
      else if (shifted[ACC_W-1])
         result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mode_r  <= 1'b0;
         shift_r <= '0;
      end else if (EN && state == IDLE && START) begin
         mode_r  <= MODE;
         shift_r <= AVG_SHIFT;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{MODE, AVG_SHIFT};
   assign v          = first ? din_ext : v_max;
   assign result     = v[DATA_WIDTH-1:0];
`endif

   assign BUSY = (state != IDLE);

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      first_nxt = first;
      cnt_nxt   = cnt;
      valid_nxt = 1'b0;
      dout_nxt  = DOUT;
      addr_nxt  = DOUT_ADDR;
      last_nxt  = 1'b0;
      err_nxt   = ERR;
      case (state)
         IDLE: begin
            if (START) begin
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
               first_nxt = 1'b1;
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (DIN_VALID) begin
               // A truncated map still flushes its partial window as a result.
               if (DIN_PACK || DIN_LAST) begin
                  valid_nxt = 1'b1;
                  dout_nxt  = result;
                  addr_nxt  = cnt;
                  cnt_nxt   = cnt + 1'b1;
                  first_nxt = 1'b1;
                  if (DIN_LAST) begin
                     last_nxt  = 1'b1;
                     state_nxt = DONE;
                     if (!DIN_PACK)
                        err_nxt = 1'b1;
                  end
               end else begin
                  acc_nxt   = v;
                  first_nxt = 1'b0;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         acc        <= '0;
         first      <= 1'b1;
         cnt        <= '0;
         DOUT_VALID <= 1'b0;
         DOUT       <= '0;
         DOUT_ADDR  <= '0;
         DOUT_LAST  <= 1'b0;
         ERR        <= 1'b0;
      end else if (EN) begin
         state      <= state_nxt;
         acc        <= acc_nxt;
         first      <= first_nxt;
         cnt        <= cnt_nxt;
         DOUT_VALID <= valid_nxt;
         DOUT       <= dout_nxt;
         DOUT_ADDR  <= addr_nxt;
         DOUT_LAST  <= last_nxt;
         ERR        <= err_nxt;
      end
   end

endmodule

// File: doc/pool_reduce.md
# pool_reduce

- Pooling-window reducer sitting downstream of the pooling address generator on the same `EN` domain.
- Consumes the ifmap values read at the generated addresses, qualified by that generator's valid / window-last / last flags (delayed upstream to align with read data).
- Reduces each window to one value (max, optionally average) and emits it with a sequential output address for write-back.

## Interface
- `DATA_WIDTH`, 16, signed width of input and output samples
- `ADDR_WIDTH`, 12, width of the output address counter
- `ACC_EXTRA`, 10, guard bits of the sum accumulator (covers 31×31 window)
- `SHIFT_WIDTH`, 4, width of `AVG_SHIFT`
- `CLK`  in  1  clock; one clock, all logic on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `EN`  in  1  global clock enable; when low every register holds
- `START`  in  1  begin a new feature map; sampled only in IDLE
- `MODE`  in  1  0 = max pooling, 1 = average pooling; latched on START
- `AVG_SHIFT`  in  SHIFT_WIDTH  log2 of window area for average; latched on START
- `DIN_VALID`  in  1  `DIN` and flags valid this cycle
- `DIN`  in  DATA_WIDTH  signed sample
- `DIN_PACK`  in  1  sample is last of its window
- `DIN_LAST`  in  1  sample is last of the feature map
- `DOUT_VALID`  out  1  one-cycle pulse, pooled result valid
- `DOUT`  out  DATA_WIDTH  pooled result
- `DOUT_ADDR`  out  ADDR_WIDTH  output address of `DOUT`, 0-based, row-major
- `DOUT_LAST`  out  1  with `DOUT_VALID`: final result of the map
- `BUSY`  out  1  high while not IDLE
- `ERR`  out  1  sticky: window truncated by `DIN_LAST` without `DIN_PACK`; cleared by RESET or START

## Operation
- States:
  - IDLE (00): on `EN && START`, latch `MODE`/`AVG_SHIFT`, clear out-address counter and `ERR`, set `first`, go ACC.
  - ACC (01): reduce samples.
  - DONE (10): one cycle, then IDLE.
- `DIN_VALID` is ignored in IDLE and DONE. `START` is ignored outside IDLE.
- In ACC, on `EN && DIN_VALID`:
  - Window value `v` = `DIN` if `first`, else max(`acc`, `DIN`) (signed compare) or `acc` + sign-extended `DIN`.
  - If not `DIN_PACK`: `acc <= v`, `first <= 0`.
  - If `DIN_PACK`: register result from `v` (bypassing `acc`), `DOUT_VALID <= 1`, `DOUT_ADDR <= cnt`, `cnt <= cnt + 1` (wraps modulo 2^ADDR_WIDTH), `first <= 1`.
- Max result = `v`.
- Average result = `v >>> AVG_SHIFT` (arithmetic), saturated to the signed DATA_WIDTH range.
- Accumulator width is DATA_WIDTH+ACC_EXTRA. Overflow beyond that is not detected.
- `DIN_LAST` with `DIN_PACK`: emit as above with `DOUT_LAST = 1`, go DONE.
- `DIN_LAST` without `DIN_PACK`: flush partial `v` as a result anyway with `DOUT_LAST = 1`, set `ERR`, go DONE.
- Back-to-back windows, including 1×1 windows (`DIN_PACK` on every sample), sustain one result per valid cycle.

## Timing
- Reset values: `DOUT_VALID` 0, `DOUT` 0, `DOUT_ADDR` 0, `DOUT_LAST` 0, `BUSY` 0, `ERR` 0. State resets to IDLE; `acc` 0; `cnt` 0; `first` 1.
- Latency: `DOUT_VALID` rises on the `EN` cycle after the `DIN_VALID && DIN_PACK` cycle; pulse width is one `EN` cycle.
- `BUSY` rises the cycle after START is accepted and falls on the DONE→IDLE transition. `DOUT_LAST` and the final `DOUT_VALID` coincide with the DONE state.
- `EN` low holds all registers, including outputs. Downstream qualifies `DOUT_VALID` with `EN`.
- RESET mid-map: returns to IDLE next edge; any partial window is discarded with no output pulse.
- No backpressure; the consumer always accepts.

## Configuration
- `POOL_AVG_EN` defined: sum accumulator, shifter and saturation are compiled in, and `MODE`=1 selects average pooling.
- `POOL_AVG_EN` undefined: max pooling only. `MODE` and `AVG_SHIFT` are ignored and the accumulator is DATA_WIDTH wide.

## Test plan
- 2×2 max over 4×4 map, rows 0..15 in raster window order:
  - Stimulus: windows {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15}.
  - Required: `DOUT` 5,7,13,15 at `DOUT_ADDR` 0..3; `DOUT_LAST` only with 15; `ERR` 0.
- Signed max, window {-3,-9,-1,-7}: `DOUT` = -1. Window of all -32768: `DOUT` = -32768.
- Average (`POOL_AVG_EN`, `MODE`=1, `AVG_SHIFT`=2):
  - Window {10,20,30,41}: `DOUT` = 25.
  - Window {32767×4} with `AVG_SHIFT`=0: saturates to 32767.
- Truncation: `DIN_LAST` on the 3rd sample of {4,9,2} with no `DIN_PACK` → `DOUT` 9, `DOUT_LAST` 1, `ERR` 1. A following START clears `ERR`.
- `EN` toggling 1-0-1 every cycle during 2×2 max: results identical to case 1, each pulse held through `EN`-low cycles.
- RESET asserted after 2 samples of a window: no `DOUT_VALID`, state IDLE. A new START restarts `DOUT_ADDR` at 0.
